// File: rtl/ind_pipe_arbiter_pkg.sv
// Shared defaults, index-width helper and message type for the indication pipe arbiter.
package ind_pipe_arbiter_pkg;

  localparam int DEF_NUM_SRC    = 4;
  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_LEN_WIDTH  = 16;

  // Width of a source index; never narrower than one bit.
  function automatic int src_idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int SRC_IDX_WIDTH = src_idx_width(DEF_NUM_SRC);

  // One indication message at the default widths.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] v;
    logic [DEF_LEN_WIDTH-1:0]  length;
  } msg_t;

endpackage

// File: rtl/ind_pipe_arbiter_if.sv
// Bundle of the per-source enq pipes and the shared host-facing enq pipe.
interface ind_pipe_arbiter_if
  import ind_pipe_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);

  logic [NUM_SRC-1:0]            in_enq_ena;
  logic [NUM_SRC*DATA_WIDTH-1:0] in_enq_v;
  logic [NUM_SRC*LEN_WIDTH-1:0]  in_enq_length;
  logic [NUM_SRC-1:0]            in_enq_rdy;

  logic                          out_enq_ena;
  logic [DATA_WIDTH-1:0]         out_enq_v;
  logic [LEN_WIDTH-1:0]          out_enq_length;
  logic                          out_enq_rdy;

  // Sources plus the downstream pipe (environment side).
  modport master (
    output in_enq_ena, in_enq_v, in_enq_length, out_enq_rdy,
    input  in_enq_rdy, out_enq_ena, out_enq_v, out_enq_length
  );

  // The arbiter itself.
  modport slave (
    input  in_enq_ena, in_enq_v, in_enq_length, out_enq_rdy,
    output in_enq_rdy, out_enq_ena, out_enq_v, out_enq_length
  );

endinterface

// File: rtl/ind_pipe_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping modulo NUM_SRC.
module ind_pipe_arbiter_rr_arbiter
  import ind_pipe_arbiter_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int IDX_W   = src_idx_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_gnt_o
);

  // Scan candidates ptr, ptr+1, ... and keep the first one that is requesting.
  always_comb begin
    int cand;
    cand      = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_gnt_o = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = (int'(ptr_i) + k) % NUM_SRC;
      if (!any_gnt_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand[IDX_W-1:0];
        any_gnt_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ind_pipe_arbiter.sv
// Shares one indication pipe between NUM_SRC sources: one buffered slot per source,
// a single output register, round-robin selection and a delivered-message counter.
module ind_pipe_arbiter
  import ind_pipe_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  ind_pipe_arbiter_if.slave    pipe,
  output logic [31:0]          out_count,
  output logic [2:0]           last_src
);

  localparam int IDX_W = src_idx_width(NUM_SRC);

  logic [NUM_SRC-1:0]    slot_valid;
  logic [DATA_WIDTH-1:0] slot_v   [NUM_SRC];
  logic [LEN_WIDTH-1:0]  slot_len [NUM_SRC];

  logic [NUM_SRC-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  any_gnt;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_v_q, out_v_d;
  logic [LEN_WIDTH-1:0]  out_len_q, out_len_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [2:0]            last_src_q, last_src_d;
  logic [31:0]           out_count_q, out_count_d;

  logic xfer;
  logic load;
  logic take;

  // The output register may be refilled when it is empty or emptying this cycle.
  assign xfer = out_valid_q & pipe.out_enq_rdy;
  assign load = ~out_valid_q | xfer;
  assign take = load & any_gnt;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
      logic                  valid_q;
      logic [DATA_WIDTH-1:0] v_q;
      logic [LEN_WIDTH-1:0]  len_q;

      // Slot occupancy: filled by the source's enq, emptied when granted.
      always_ff @(posedge CLK) begin
        if (RST) begin
          valid_q <= 1'b0;
        end else if (pipe.in_enq_ena[gi] && !valid_q) begin
          valid_q <= 1'b1;
        end else if (take && gnt[gi]) begin
          valid_q <= 1'b0;
        end
      end

      // Slot payload capture; contents are don't-care while the slot is empty.
      always_ff @(posedge CLK) begin
        if (pipe.in_enq_ena[gi] && !valid_q) begin
          v_q   <= pipe.in_enq_v[gi*DATA_WIDTH +: DATA_WIDTH];
          len_q <= pipe.in_enq_length[gi*LEN_WIDTH +: LEN_WIDTH];
        end
      end

      assign slot_valid[gi] = valid_q;
      assign slot_v[gi]     = v_q;
      assign slot_len[gi]   = len_q;
    end
  endgenerate

  ind_pipe_arbiter_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i     (slot_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_gnt_o (any_gnt)
  );

  // Next state of the output stage, pointer and counters.
  always_comb begin
    out_valid_d = out_valid_q;
    out_v_d     = out_v_q;
    out_len_d   = out_len_q;
    ptr_d       = ptr_q;
    last_src_d  = last_src_q;
    out_count_d = xfer ? out_count_q + 32'd1 : out_count_q;
    if (load) begin
      out_valid_d = any_gnt;
      if (any_gnt) begin
        out_v_d    = slot_v[gnt_idx];
        out_len_d  = slot_len[gnt_idx];
        ptr_d      = (gnt_idx == IDX_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
        last_src_d = 3'(gnt_idx);
      end
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
      last_src_q  <= '0;
      out_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      last_src_q  <= last_src_d;
      out_count_q <= out_count_d;
    end
  end

  // Output payload; only meaningful while out_valid_q is set.
  always_ff @(posedge CLK) begin
    out_v_q   <= out_v_d;
    out_len_q <= out_len_d;
  end

  assign pipe.in_enq_rdy     = ~slot_valid;
  assign pipe.out_enq_ena    = xfer;
  assign pipe.out_enq_v      = out_v_q;
  assign pipe.out_enq_length = out_len_q;
  assign out_count           = out_count_q;
  assign last_src            = last_src_q;

endmodule

// File: tb/tb_ind_pipe_arbiter.sv
// Directed bench for ind_pipe_arbiter with per-source expected-message queues.
module tb_ind_pipe_arbiter;
  import ind_pipe_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 128;
  localparam int LW = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] out_count;
  logic [2:0]  last_src;

  always #5 CLK = ~CLK;

  ind_pipe_arbiter_if #(.NUM_SRC(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  ind_pipe_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .pipe      (bus),
    .out_count (out_count),
    .last_src  (last_src)
  );

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  msg_t        q_src[N][$];
  int          exp_order[$];
  logic [31:0] exp_cnt;
  int          deliv[N];
  int          ena_seen;
  int          seq_cnt;
  msg_t        t2;
  msg_t        held;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic msg_t mk(input int src, input int seq);
    msg_t m;
    m.v      = {32'hC0DE_0000 | 32'(src), 32'(seq), 32'(seq * 32'h9E37_79B9), 32'(~seq)};
    m.length = 16'(seq * 4 + src);
    return m;
  endfunction

  function automatic bit all_empty();
    if (exp_order.size() != 0) return 1'b0;
    for (int i = 0; i < N; i++) if (q_src[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic put(input int i, input msg_t m);
    bus.in_enq_v[i*DW +: DW]      = m.v;
    bus.in_enq_length[i*LW +: LW] = m.length;
  endtask

  // Offer a fresh message on every masked source whose RDY is high, for n cycles.
  task automatic run_enq(input logic [N-1:0] mask, input int n);
    logic [N-1:0] e;
    msg_t m;
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      if (bus.out_enq_ena === 1'b1) ena_seen++;
      e = bus.in_enq_rdy & mask;
      for (int i = 0; i < N; i++) begin
        if (e[i]) begin
          m = mk(i, seq_cnt);
          seq_cnt++;
          q_src[i].push_back(m);
          put(i, m);
        end
      end
      bus.in_enq_ena = e;
    end
    @(negedge CLK);
    bus.in_enq_ena = '0;
  endtask

  task automatic wait_drain(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge CLK);
      #3;
      done = all_empty();
    end
    chk("drain_done", done, 1);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.in_enq_ena = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    exp_order.delete();
    for (int i = 0; i < N; i++) begin
      q_src[i].delete();
      deliv[i] = 0;
    end
    exp_cnt = '0;
  endtask

  // Output monitor: every transfer is matched against the expected queues.
  always @(negedge CLK) begin
    int   s;
    int   o;
    msg_t m;
    #2;
    if (!RST && bus.out_enq_ena === 1'b1) begin
      s = int'(last_src);
      chk("out_count_at_xfer", out_count, exp_cnt);
      exp_cnt = exp_cnt + 32'd1;
      chk("order_entry_present", exp_order.size() != 0, 1);
      if (exp_order.size() != 0) begin
        o = exp_order.pop_front();
        chk("grant_src", last_src, o);
      end
      if (s < N) begin
        chk("src_msg_present", q_src[s].size() != 0, 1);
        if (q_src[s].size() != 0) begin
          m = q_src[s].pop_front();
          chk("out_v", bus.out_enq_v, m.v);
          chk("out_length", bus.out_enq_length, m.length);
          $display("xfer src=%0d len=%0h count=%0h", s, bus.out_enq_length, out_count);
        end
        deliv[s]++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mx, mn, sum;
    RST               = 1'b1;
    bus.in_enq_ena    = '0;
    bus.in_enq_v      = '0;
    bus.in_enq_length = '0;
    bus.out_enq_rdy   = 1'b1;
    seq_cnt           = 0;
    ena_seen          = 0;
    exp_cnt           = '0;
    for (int i = 0; i < N; i++) deliv[i] = 0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // 1: reset state, then a reset in the middle of traffic
    @(negedge CLK);
    chk("t1_rdy", bus.in_enq_rdy, 4'hF);
    chk("t1_out_ena", bus.out_enq_ena, 0);
    chk("t1_out_count", out_count, 0);
    chk("t1_last_src", last_src, 0);
    put(0, mk(0, 900));
    put(1, mk(1, 901));
    bus.in_enq_ena = 4'b0011;
    @(negedge CLK);
    bus.in_enq_ena = '0;
    chk("t1_rdy_loaded", bus.in_enq_rdy, 4'b1100);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("t1_post_rst_rdy", bus.in_enq_rdy, 4'hF);
      chk("t1_post_rst_ena", bus.out_enq_ena, 0);
      chk("t1_post_rst_count", out_count, 0);
    end

    // 2: single source latency
    t2.v      = 128'h0123456789ABCDEF0123456789ABCDEF;
    t2.length = 16'd16;
    @(negedge CLK);
    put(2, t2);
    q_src[2].push_back(t2);
    exp_order.push_back(2);
    bus.in_enq_ena = 4'b0100;
    @(negedge CLK);
    bus.in_enq_ena = '0;
    chk("t2_ena_slot_stage", bus.out_enq_ena, 0);
    chk("t2_rdy_slot_full", bus.in_enq_rdy, 4'b1011);
    @(negedge CLK);
    chk("t2_ena_t_plus_2", bus.out_enq_ena, 1);
    chk("t2_last_src", last_src, 2);
    chk("t2_v", bus.out_enq_v, t2.v);
    chk("t2_len", bus.out_enq_length, 16);
    @(negedge CLK);
    chk("t2_count", out_count, 1);
    chk("t2_ena_done", bus.out_enq_ena, 0);
    chk("t2_rdy_free", bus.in_enq_rdy, 4'hF);

    // 3: all sources busy -> strict rotation, one transfer per cycle
    do_reset();
    for (int k = 0; k < 42; k++) exp_order.push_back(k % 4);
    ena_seen = 0;
    run_enq(4'hF, 40);
    chk("t3_ena_every_cycle", ena_seen, 38);
    wait_drain(40);
    mx = deliv[0]; mn = deliv[0]; sum = 0;
    for (int i = 0; i < N; i++) begin
      if (deliv[i] > mx) mx = deliv[i];
      if (deliv[i] < mn) mn = deliv[i];
      sum += deliv[i];
    end
    chk("t3_fairness", (mx - mn) <= 1, 1);
    chk("t3_total", sum, 42);

    // 4: backpressure with every slot and the output register full
    do_reset();
    bus.out_enq_rdy = 1'b0;
    exp_order.push_back(0); exp_order.push_back(1); exp_order.push_back(2);
    exp_order.push_back(3); exp_order.push_back(0);
    run_enq(4'hF, 3);
    held = q_src[0][0];
    for (int i = 0; i < 20; i++) begin
      chk("t4_rdy_blocked", bus.in_enq_rdy, 4'h0);
      chk("t4_no_ena", bus.out_enq_ena, 0);
      chk("t4_held_v", bus.out_enq_v, held.v);
      chk("t4_held_len", bus.out_enq_length, held.length);
      @(negedge CLK);
    end
    bus.out_enq_rdy = 1'b1;
    wait_drain(20);
    sum = 0;
    for (int i = 0; i < N; i++) sum += deliv[i];
    chk("t4_drained_5", sum, 5);

    // 5: pointer wrap and skipping idle sources (ptr left at 2 by a src1 message)
    do_reset();
    exp_order.push_back(1);
    run_enq(4'b0010, 1);
    wait_drain(10);
    exp_order.push_back(3); exp_order.push_back(1); exp_order.push_back(3);
    run_enq(4'b1010, 3);
    wait_drain(10);
    chk("t5_src1_count", deliv[1], 2);
    chk("t5_src3_count", deliv[3], 2);

    // 6: delivered-count wrap
    @(negedge CLK);
    force dut.out_count_q = 32'hFFFF_FFFE;
    @(negedge CLK);
    release dut.out_count_q;
    exp_cnt = 32'hFFFF_FFFE;
    chk("t6_preset", out_count, 32'hFFFF_FFFE);
    exp_order.push_back(0); exp_order.push_back(1); exp_order.push_back(2);
    run_enq(4'b0111, 1);
    wait_drain(10);
    @(negedge CLK);
    chk("t6_count_wrapped", out_count, 32'h0000_0001);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
